// File: rtl/usb_in_ep_sched.sv
// usb_in_ep_sched
//   Shares the USB device's single IN-transaction interface between NumEps
//   IN endpoints. An accepted IN token latches the addressed endpoint, and
//   data/get/ack/rollback are routed to it until the transaction ends.
//   A DATA0/DATA1 toggle bit is kept per endpoint. An Active transaction
//   that sees no byte fetch for TimeoutCycles cycles is rolled back.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   in_token_i            IN token pulse; in_ep_num_i is sampled with it
//   in_get_addr_i         byte address from packet engine (broadcast)
//   in_data_get_i         byte-consumed strobe (routed to selected ep)
//   in_acked_i            host ACK; ends the transaction, flips toggle
//   in_rollback_i         transaction failed; ends the transaction
//   in_setup_i            SETUP pulse; forces toggle[in_setup_ep_i] to DATA1
//   in_has_data_o, in_stall_o, in_data_o, in_data_done_o
//                         selected endpoint's status/byte (0 when idle)
//   in_data_toggle_o      PID toggle of the selected endpoint
//   in_busy_o             a transaction is active
//   ep_enable_i, ep_has_data_i, ep_stall_i, ep_data_done_i, ep_data_i
//                         per-endpoint inputs (byte k at [8k+7:8k])
//   ep_get_addr_o         in_get_addr_i broadcast
//   ep_data_get_o         one-hot get strobe
//   ep_acked_o            registered one-hot ack pulse
//   ep_rollback_o         registered one-hot rollback pulse
module usb_in_ep_sched #(
    parameter int unsigned NumEps         = 4,
    parameter int unsigned MaxPktSizeByte = 32,
    parameter int unsigned PktW           = $clog2(MaxPktSizeByte),
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_token_i,
    input  logic [3:0]          in_ep_num_i,
    input  logic [PktW-1:0]     in_get_addr_i,
    input  logic                in_data_get_i,
    input  logic                in_acked_i,
    input  logic                in_rollback_i,
    input  logic                in_setup_i,
    input  logic [3:0]          in_setup_ep_i,
    output logic                in_has_data_o,
    output logic                in_stall_o,
    output logic [7:0]          in_data_o,
    output logic                in_data_done_o,
    output logic                in_data_toggle_o,
    output logic                in_busy_o,
    input  logic [NumEps-1:0]   ep_enable_i,
    input  logic [NumEps-1:0]   ep_has_data_i,
    input  logic [NumEps-1:0]   ep_stall_i,
    input  logic [NumEps-1:0]   ep_data_done_i,
    input  logic [8*NumEps-1:0] ep_data_i,
    output logic [PktW-1:0]     ep_get_addr_o,
    output logic [NumEps-1:0]   ep_data_get_o,
    output logic [NumEps-1:0]   ep_acked_o,
    output logic [NumEps-1:0]   ep_rollback_o
);

    localparam int unsigned SelW = (NumEps > 1) ? $clog2(NumEps) : 1;
    localparam int unsigned CntW = $clog2(TimeoutCycles);

    typedef enum logic {
        StIdle,
        StActive
    } state_e;

    state_e              state_q;
    logic [SelW-1:0]     sel_q;
    logic [CntW-1:0]     cnt_q;
    logic [NumEps-1:0]   toggle_q;
    logic [NumEps-1:0]   acked_q;
    logic [NumEps-1:0]   rollback_q;

    logic                tok_valid;
    logic [SelW-1:0]     tok_sel;
    logic [NumEps-1:0]   setup_oh;
    logic                timeout;

    // Decode token/setup endpoint numbers against the full 4-bit field so
    // out-of-range numbers simply match nothing.
    always_comb begin
        tok_valid = 1'b0;
        tok_sel   = '0;
        setup_oh  = '0;
        for (int unsigned k = 0; k < NumEps; k++) begin
            if (in_ep_num_i == 4'(k)) begin
                tok_valid = in_token_i & ep_enable_i[k];
                tok_sel   = SelW'(k);
            end
            setup_oh[k] = in_setup_i && (in_setup_ep_i == 4'(k));
        end
    end

    // A fetch in the final cycle counts as activity and prevents the timeout.
    assign timeout = (cnt_q == CntW'(TimeoutCycles - 1)) && !in_data_get_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            cnt_q      <= '0;
            toggle_q   <= '0;
            acked_q    <= '0;
            rollback_q <= '0;
        end else begin
            acked_q    <= '0;
            rollback_q <= '0;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (tok_valid) begin
                        state_q <= StActive;
                        sel_q   <= tok_sel;
                    end
                end
                StActive: begin
                    cnt_q <= in_data_get_i ? '0 : cnt_q + 1'b1;
                    // Ack closes the old transaction cleanly even when a new
                    // token arrives in the same cycle; otherwise any ending
                    // or preemption rolls the old endpoint back.
                    if (in_acked_i) begin
                        acked_q[sel_q]  <= 1'b1;
                        toggle_q[sel_q] <= ~toggle_q[sel_q];
                    end else if (in_rollback_i || in_token_i || timeout) begin
                        rollback_q[sel_q] <= 1'b1;
                    end
                    if (in_token_i) begin
                        cnt_q <= '0;
                        if (tok_valid) sel_q <= tok_sel;
                        else           state_q <= StIdle;
                    end else if (in_acked_i || in_rollback_i || timeout) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Placed last so SETUP overrides an ack flip on the same endpoint.
            for (int unsigned k = 0; k < NumEps; k++) begin
                if (setup_oh[k]) toggle_q[k] <= 1'b1;
            end
        end
    end

    always_comb begin
        in_has_data_o    = 1'b0;
        in_stall_o       = 1'b0;
        in_data_o        = '0;
        in_data_done_o   = 1'b0;
        in_data_toggle_o = 1'b0;
        in_busy_o        = 1'b0;
        ep_data_get_o    = '0;
        if (state_q == StActive) begin
            in_busy_o = 1'b1;
            for (int unsigned k = 0; k < NumEps; k++) begin
                if (sel_q == SelW'(k)) begin
                    in_has_data_o    = ep_has_data_i[k];
                    in_stall_o       = ep_stall_i[k];
                    in_data_o        = ep_data_i[8*k +: 8];
                    in_data_done_o   = ep_data_done_i[k];
                    in_data_toggle_o = toggle_q[k];
                    ep_data_get_o[k] = in_data_get_i;
                end
            end
        end
    end

    assign ep_get_addr_o = in_get_addr_i;
    assign ep_acked_o    = acked_q;
    assign ep_rollback_o = rollback_q;

endmodule

// File: tb/tb_usb_in_ep_sched.sv
module tb_usb_in_ep_sched;

    localparam int NEPS = 4;
    localparam int T    = 1024;
    localparam int PKTW = 5;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              in_token_i, in_data_get_i, in_acked_i, in_rollback_i, in_setup_i;
    logic [3:0]        in_ep_num_i, in_setup_ep_i;
    logic [PKTW-1:0]   in_get_addr_i;
    logic              in_has_data_o, in_stall_o, in_data_done_o, in_data_toggle_o, in_busy_o;
    logic [7:0]        in_data_o;
    logic [NEPS-1:0]   ep_enable_i, ep_has_data_i, ep_stall_i, ep_data_done_i;
    logic [8*NEPS-1:0] ep_data_i;
    logic [PKTW-1:0]   ep_get_addr_o;
    logic [NEPS-1:0]   ep_data_get_o, ep_acked_o, ep_rollback_o;

    usb_in_ep_sched #(
        .NumEps(NEPS),
        .MaxPktSizeByte(32),
        .PktW(PKTW),
        .TimeoutCycles(T)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_token_i(in_token_i), .in_ep_num_i(in_ep_num_i),
        .in_get_addr_i(in_get_addr_i), .in_data_get_i(in_data_get_i),
        .in_acked_i(in_acked_i), .in_rollback_i(in_rollback_i),
        .in_setup_i(in_setup_i), .in_setup_ep_i(in_setup_ep_i),
        .in_has_data_o(in_has_data_o), .in_stall_o(in_stall_o),
        .in_data_o(in_data_o), .in_data_done_o(in_data_done_o),
        .in_data_toggle_o(in_data_toggle_o), .in_busy_o(in_busy_o),
        .ep_enable_i(ep_enable_i), .ep_has_data_i(ep_has_data_i),
        .ep_stall_i(ep_stall_i), .ep_data_done_i(ep_data_done_i),
        .ep_data_i(ep_data_i), .ep_get_addr_o(ep_get_addr_o),
        .ep_data_get_o(ep_data_get_o), .ep_acked_o(ep_acked_o),
        .ep_rollback_o(ep_rollback_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: which endpoint owns the bus (-1 = none), the PID
    // toggle per endpoint and the number of idle Active cycles.
    int cur = -1;
    bit tog[NEPS];
    int idle = 0;
    int pend_ack = -1;
    int pend_rb  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NEPS-1:0] oh(input int i);
        if (i < 0) return '0;
        return NEPS'(1 << i);
    endfunction

    task automatic clear_inputs();
        in_token_i    = 1'b0;
        in_ep_num_i   = 4'd0;
        in_data_get_i = 1'b0;
        in_acked_i    = 1'b0;
        in_rollback_i = 1'b0;
        in_setup_i    = 1'b0;
        in_setup_ep_i = 4'd0;
    endtask

    task automatic check_comb();
        logic eh, es, ed, et;
        logic [7:0] edat;
        logic [NEPS-1:0] eg;
        eh = 1'b0; es = 1'b0; ed = 1'b0; et = 1'b0; edat = 8'h00; eg = '0;
        if (cur >= 0) begin
            eh   = ep_has_data_i[cur];
            es   = ep_stall_i[cur];
            ed   = ep_data_done_i[cur];
            edat = ep_data_i[cur*8 +: 8];
            et   = tog[cur];
            eg   = in_data_get_i ? oh(cur) : '0;
        end
        chk("busy", in_busy_o, (cur >= 0) ? 1 : 0);
        chk("has_data", in_has_data_o, eh);
        chk("stall", in_stall_o, es);
        chk("data_done", in_data_done_o, ed);
        chk("data", in_data_o, edat);
        chk("toggle", in_data_toggle_o, et);
        chk("get_route", ep_data_get_o, eg);
        chk("get_addr", ep_get_addr_o, in_get_addr_i);
    endtask

    task automatic model_next();
        int ep;
        bit valid, to;
        int old;
        ep = int'(in_ep_num_i);
        valid = 0;
        if (in_token_i && ep < NEPS) valid = ep_enable_i[ep];
        pend_ack = -1;
        pend_rb  = -1;
        if (cur < 0) begin
            if (valid) begin
                cur  = ep;
                idle = 0;
            end
        end else begin
            old = cur;
            to  = (idle == T - 1) && !in_data_get_i;
            if (in_acked_i) begin
                pend_ack = old;
                tog[old] = ~tog[old];
            end else if (in_rollback_i || in_token_i || to) begin
                pend_rb = old;
            end
            if (in_token_i) begin
                cur  = valid ? ep : -1;
                idle = 0;
            end else if (in_acked_i || in_rollback_i || to) begin
                cur = -1;
            end else begin
                idle = in_data_get_i ? 0 : idle + 1;
            end
        end
        if (in_setup_i && int'(in_setup_ep_i) < NEPS) tog[in_setup_ep_i] = 1'b1;
    endtask

    // One clock cycle with the inputs currently driven.
    task automatic step();
        #1;
        check_comb();
        model_next();
        @(posedge clk_i);
        #1;
        chk("ack_pulse", ep_acked_o, oh(pend_ack));
        chk("rb_pulse", ep_rollback_o, oh(pend_rb));
    endtask

    task automatic token(input int ep);
        in_token_i  = 1'b1;
        in_ep_num_i = 4'(ep);
        step();
        clear_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        rst_ni         = 1'b0;
        clear_inputs();
        in_data_get_i  = 1'b1;
        in_get_addr_i  = '0;
        ep_enable_i    = '1;
        ep_has_data_i  = '1;
        ep_stall_i     = '1;
        ep_data_done_i = '1;
        ep_data_i      = 32'h44_33_22_11;
        #3;
        chk("rst_busy", in_busy_o, 0);
        chk("rst_has_data", in_has_data_o, 0);
        chk("rst_data", in_data_o, 0);
        chk("rst_toggle", in_data_toggle_o, 0);
        chk("rst_get", ep_data_get_o, 0);
        chk("rst_ack", ep_acked_o, 0);
        chk("rst_rb", ep_rollback_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        clear_inputs();
        ep_stall_i     = '0;
        ep_data_done_i = 4'b0010;

        // Normal transaction on ep 1 with four fetches then ACK.
        token(1);
        #1;
        chk("t1_busy", in_busy_o, 1);
        chk("t1_tog", in_data_toggle_o, 0);
        for (int i = 0; i < 4; i++) begin
            in_data_get_i = 1'b1;
            in_get_addr_i = PKTW'(i);
            #1;
            chk("t1_get", ep_data_get_o, 4'b0010);
            step();
        end
        clear_inputs();
        in_acked_i = 1'b1;
        step();
        chk("t1_ack", ep_acked_o, 4'b0010);
        clear_inputs();
        #1;
        chk("t1_idle", in_busy_o, 0);
        step();
        token(1);
        #1;
        chk("t1_tog_flipped", in_data_toggle_o, 1);
        in_rollback_i = 1'b1;
        step();
        clear_inputs();

        // Rollback on ep 2 leaves its toggle alone.
        token(2);
        in_rollback_i = 1'b1;
        step();
        chk("t2_rb", ep_rollback_o, 4'b0100);
        clear_inputs();
        #1;
        chk("t2_idle", in_busy_o, 0);
        token(2);
        #1;
        chk("t2_tog", in_data_toggle_o, 0);
        in_rollback_i = 1'b1;
        step();
        clear_inputs();

        // SETUP forces DATA1, and wins over a same-cycle ack flip.
        in_setup_i = 1'b1;
        in_setup_ep_i = 4'd0;
        step();
        clear_inputs();
        token(0);
        #1;
        chk("t3_setup_tog", in_data_toggle_o, 1);
        in_acked_i = 1'b1;
        in_setup_i = 1'b1;
        in_setup_ep_i = 4'd0;
        step();
        clear_inputs();
        token(0);
        #1;
        chk("t3_setup_over_ack", in_data_toggle_o, 1);
        in_rollback_i = 1'b1;
        step();
        clear_inputs();

        // Timeout on ep 3.
        token(3);
        got = 0;
        for (int n = 1; n <= T + 5; n++) begin
            step();
            if (ep_rollback_o != 0) begin
                got = n;
                break;
            end
        end
        chk("t4_timeout_cycles", got, T);
        chk("t4_timeout_rb", ep_rollback_o, 4'b1000);
        #1;
        chk("t4_timeout_idle", in_busy_o, 0);

        // Periodic fetches keep the transaction alive.
        token(3);
        for (int n = 1; n <= 1600; n++) begin
            in_data_get_i = (n % 500 == 0);
            step();
        end
        clear_inputs();
        #1;
        chk("t4_alive", in_busy_o, 1);
        in_acked_i = 1'b1;
        step();
        clear_inputs();

        // Out-of-range and disabled endpoints are ignored.
        token(5);
        #1;
        chk("t5_range_busy", in_busy_o, 0);
        ep_enable_i = 4'b1101;
        in_data_get_i = 1'b1;
        token(1);
        in_data_get_i = 1'b1;
        #1;
        chk("t5_dis_busy", in_busy_o, 0);
        chk("t5_dis_get", ep_data_get_o, 0);
        in_acked_i = 1'b1;
        step();
        chk("t5_dis_noack", ep_acked_o, 0);
        clear_inputs();
        ep_enable_i = '1;

        // Preemption: ep 1 then ep 2 two cycles later.
        token(1);
        step();
        token(2);
        chk("t6_preempt_rb", ep_rollback_o, 4'b0010);
        #1;
        chk("t6_new_sel_data", in_data_o, 8'h33);
        in_acked_i = 1'b1;
        step();
        chk("t6_ack", ep_acked_o, 4'b0100);
        clear_inputs();
        step();

        // Asynchronous reset mid-transaction clears toggles.
        token(1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t7_rst_busy", in_busy_o, 0);
        chk("t7_rst_ack", ep_acked_o, 0);
        chk("t7_rst_rb", ep_rollback_o, 0);
        cur = -1;
        idle = 0;
        for (int k = 0; k < NEPS; k++) tog[k] = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        token(1);
        #1;
        chk("t7_tog_cleared", in_data_toggle_o, 0);
        in_rollback_i = 1'b1;
        step();
        clear_inputs();

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            in_token_i     = ($urandom_range(0, 7) == 0);
            in_ep_num_i    = 4'($urandom_range(0, 7));
            in_acked_i     = ($urandom_range(0, 9) == 0);
            in_rollback_i  = ($urandom_range(0, 11) == 0);
            in_data_get_i  = ($urandom_range(0, 2) == 0);
            in_setup_i     = ($urandom_range(0, 15) == 0);
            in_setup_ep_i  = 4'($urandom_range(0, 7));
            in_get_addr_i  = PKTW'($urandom);
            if (in_acked_i) in_token_i = 1'b0;
            ep_enable_i    = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            ep_has_data_i  = 4'($urandom);
            ep_stall_i     = 4'($urandom);
            ep_data_done_i = 4'($urandom);
            ep_data_i      = $urandom;
            step();
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
